// File: rtl/aes_pkg.sv
// aes_pkg: shared AES-128 constants and sequencer state encoding
package aes_pkg;
    localparam int AES_BLOCK_W   = 128;
    localparam int AES128_ROUNDS = 10;
    localparam int AES_RND_W     = 4;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } seq_state_e;
endpackage

// File: rtl/aes_round_sequencer_if.sv
// aes_round_sequencer_if: block I/O, round datapath and round-key store signals of the sequencer
interface aes_round_sequencer_if import aes_pkg::*; #(
    parameter int DATA_LEN = AES_BLOCK_W,
    parameter int RND_W    = AES_RND_W
) ();
    logic                in_valid;
    logic                in_ready;
    logic [DATA_LEN-1:0] in_data;
    logic                out_valid;
    logic                out_ready;
    logic [DATA_LEN-1:0] out_data;
    logic                dp_valid_in;
    logic [DATA_LEN-1:0] dp_data_in;
    logic                dp_final;
    logic                dp_valid_out;
    logic [DATA_LEN-1:0] dp_data_out;
    logic [RND_W-1:0]    rk_idx;
    logic [DATA_LEN-1:0] rk_data;
    logic                busy;
    logic [RND_W-1:0]    round;
    logic                err;
    modport master (
        input  in_valid, in_data, out_ready, dp_valid_out, dp_data_out, rk_data,
        output in_ready, out_valid, out_data, dp_valid_in, dp_data_in, dp_final, rk_idx, busy, round, err
    );
    modport slave (
        output in_valid, in_data, out_ready, dp_valid_out, dp_data_out, rk_data,
        input  in_ready, out_valid, out_data, dp_valid_in, dp_data_in, dp_final, rk_idx, busy, round, err
    );
endinterface

// File: rtl/aes_round_sequencer.sv
// aes_round_sequencer: iterative AES-128 controller driving a shared round datapath with inline AddRoundKey
module aes_round_sequencer import aes_pkg::*; #(
    parameter int DATA_LEN   = AES_BLOCK_W,
    parameter int NUM_ROUNDS = AES128_ROUNDS,
    parameter int RND_W      = AES_RND_W
) (
    input logic                   clk,
    input logic                   reset,
    aes_round_sequencer_if.master bus
);
    localparam logic [RND_W-1:0] LAST = RND_W'(NUM_ROUNDS);

    seq_state_e          state_q, state_d;
    logic [RND_W-1:0]    round_q, round_d;
    logic [DATA_LEN-1:0] state_reg_q, state_reg_d;
    logic                err_q, err_d;

    // per-block registers, cleared asynchronously so an in-flight block is dropped on reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            round_q     <= '0;
            state_reg_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            round_q     <= round_d;
            state_reg_q <= state_reg_d;
            err_q       <= err_d;
        end
    end

    // FSM sequencing, round counter and AddRoundKey; a datapath result outside WAIT only flags err
    always_comb begin
        state_d     = state_q;
        round_d     = round_q;
        state_reg_d = state_reg_q;
        err_d       = bus.dp_valid_out && (state_q != WAIT);
        case (state_q)
            IDLE: if (bus.in_valid) begin
                state_reg_d = bus.in_data ^ bus.rk_data;
                round_d     = RND_W'(1);
                state_d     = ISSUE;
            end
            ISSUE: state_d = WAIT;
            WAIT: if (bus.dp_valid_out) begin
                state_reg_d = bus.dp_data_out ^ bus.rk_data;
                if (round_q == LAST) state_d = DONE;
                else begin
                    round_d = round_q + RND_W'(1);
                    state_d = ISSUE;
                end
            end
            DONE: if (bus.out_ready) begin
                state_d = IDLE;
                round_d = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.in_ready    = state_q == IDLE;
    assign bus.busy        = state_q != IDLE;
    assign bus.out_valid   = state_q == DONE;
    assign bus.out_data    = state_reg_q;
    assign bus.dp_valid_in = state_q == ISSUE;
    assign bus.dp_data_in  = state_reg_q;
    assign bus.dp_final    = (state_q == ISSUE) && (round_q == LAST);
    assign bus.rk_idx      = (state_q == WAIT) ? round_q : '0;
    assign bus.round       = round_q;
    assign bus.err         = err_q;
endmodule
